// File: rtl/comm_sequencer_pkg.sv
// Shared definitions for the link sequencer: FSM state encoding and the
// default link timing parameters used by comm_sequencer and its baud timer.
package comm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DEF_OS           = 4;     // clocks per baud
  localparam int DEF_NBAUDS       = 6;     // RC filter length in bauds
  localparam int DEF_FLUSH_BAUDS  = 8;     // bauds flushed before measuring
  localparam int DEF_WINDOW_BAUDS = 1024;  // RX samples per BER window

endpackage

// File: rtl/comm_sequencer_baud_timer.sv
// Baud timer: intra-baud phase counter, RX phase-select latch and the two
// registered strobes that pace the TX shift register and the RX sampler.
// Ports:
//   clock, reset      system clock, async active-high reset
//   tx_en_i           run the phase counter (held at 0 when low)
//   rx_en_i           enable RX sample strobes
//   phase_i           requested RX sampling offset within a baud
//   tx_baud_en_o      1-cycle strobe, cycle after phase_cnt == OS-1
//   rx_sample_en_o    1-cycle strobe, cycle after phase_cnt == phase_sel
module comm_sequencer_baud_timer
  import comm_sequencer_pkg::*;
#(
  parameter  int OS = DEF_OS,
  localparam int PW = $clog2(OS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tx_en_i,
  input  logic          rx_en_i,
  input  logic [PW-1:0] phase_i,
  output logic          tx_baud_en_o,
  output logic          rx_sample_en_o
);

  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [PW-1:0] phase_sel_q, phase_sel_d;
  logic          tx_baud_q, tx_baud_d;
  logic          rx_samp_q, rx_samp_d;
  logic          last_phase;

  always_comb begin
    last_phase  = (phase_cnt_q == PW'(OS - 1));
    phase_cnt_d = '0;
    if (tx_en_i && !last_phase) phase_cnt_d = phase_cnt_q + 1'b1;
    // The sampling offset only changes on a baud boundary, so a mid-baud
    // switch can never produce a second or a missing sample in one baud.
    phase_sel_d = last_phase ? phase_i : phase_sel_q;
    tx_baud_d   = tx_en_i & last_phase;
    // Without a running baud clock there is no baud to sample; gating with
    // tx_en keeps the strobe at one per baud instead of one per clock.
    rx_samp_d   = tx_en_i & rx_en_i & (phase_cnt_q == phase_sel_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_cnt_q <= '0;
      phase_sel_q <= '0;
      tx_baud_q   <= 1'b0;
      rx_samp_q   <= 1'b0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      phase_sel_q <= phase_sel_d;
      tx_baud_q   <= tx_baud_d;
      rx_samp_q   <= rx_samp_d;
    end
  end

  assign tx_baud_en_o   = tx_baud_q;
  assign rx_sample_en_o = rx_samp_q;

endmodule

// File: rtl/comm_sequencer.sv
// Timing and measurement sequencer for the PRBS9 -> BPSK -> RC -> BER link.
// Paces TX bauds and RX samples (via the baud timer) and runs the measurement
// FSM: flush the filter, clear the BER counter, count one BER window.
// Ports:
//   clock, reset        system clock, async active-high reset
//   i_tx_en, i_rx_en    link enables; either low aborts to IDLE
//   i_phase             RX sampling offset within a baud
//   i_start             level start in IDLE, rising edge restarts from DONE
//   o_tx_baud_en        TX baud strobe
//   o_rx_sample_en      RX sample strobe
//   o_ber_clear         1-cycle pulse on the first MEASURE cycle
//   o_ber_window        high while in MEASURE
//   o_busy, o_done      FSM in FLUSH/MEASURE, FSM in DONE
//   o_state             raw state register
// Build option: COMM_SEQ_CONTINUOUS_EN makes DONE a single cycle that
// re-enters MEASURE with a fresh clear, giving back-to-back windows.
module comm_sequencer
  import comm_sequencer_pkg::*;
#(
  parameter  int OS           = DEF_OS,
  parameter  int NBAUDS       = DEF_NBAUDS,
  parameter  int FLUSH_BAUDS  = DEF_FLUSH_BAUDS,
  parameter  int WINDOW_BAUDS = DEF_WINDOW_BAUDS,
  localparam int PW           = $clog2(OS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_tx_en,
  input  logic          i_rx_en,
  input  logic [PW-1:0] i_phase,
  input  logic          i_start,
  output logic          o_tx_baud_en,
  output logic          o_rx_sample_en,
  output logic          o_ber_clear,
  output logic          o_ber_window,
  output logic          o_busy,
  output logic          o_done,
  output logic [1:0]    o_state
);

  // Never measure before the whole filter has been refilled.
  localparam int FLUSH_N = (FLUSH_BAUDS < NBAUDS) ? NBAUDS : FLUSH_BAUDS;
  localparam int FW      = $clog2(FLUSH_N + 1);
  localparam int WW      = $clog2(WINDOW_BAUDS + 1);

  state_t        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic          ber_clear_q, ber_clear_d;
  logic          tx_baud, rx_samp, enabled;

  comm_sequencer_baud_timer #(.OS(OS)) u_timer (
    .clock          (clock),
    .reset          (reset),
    .tx_en_i        (i_tx_en),
    .rx_en_i        (i_rx_en),
    .phase_i        (i_phase),
    .tx_baud_en_o   (tx_baud),
    .rx_sample_en_o (rx_samp)
  );

  assign enabled = i_tx_en & i_rx_en;

`ifndef COMM_SEQ_CONTINUOUS_EN
  // Restart from DONE needs a fresh rising edge so a held start is inert.
  logic start_q, start_rise;
  assign start_rise = i_start & ~start_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= i_start;
  end
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    win_cnt_d   = win_cnt_q;
    ber_clear_d = 1'b0;
    if (!enabled) begin
      state_d     = ST_IDLE;
      flush_cnt_d = '0;
      win_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_start) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
        ST_FLUSH: if (tx_baud) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == FW'(FLUSH_N - 1)) begin
            state_d     = ST_MEASURE;
            ber_clear_d = 1'b1;
            win_cnt_d   = '0;
          end
        end
        ST_MEASURE: if (rx_samp) begin
          // The terminal sample is still inside the window; DONE follows.
          win_cnt_d = win_cnt_q + 1'b1;
          if (win_cnt_q == WW'(WINDOW_BAUDS - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
`ifdef COMM_SEQ_CONTINUOUS_EN
          state_d     = ST_MEASURE;
          ber_clear_d = 1'b1;
          win_cnt_d   = '0;
`else
          if (start_rise) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      win_cnt_q   <= '0;
      ber_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      win_cnt_q   <= win_cnt_d;
      ber_clear_q <= ber_clear_d;
    end
  end

  assign o_tx_baud_en   = tx_baud;
  assign o_rx_sample_en = rx_samp;
  assign o_ber_clear    = ber_clear_q;
  assign o_ber_window   = (state_q == ST_MEASURE);
  assign o_busy         = (state_q == ST_FLUSH) || (state_q == ST_MEASURE);
  assign o_done         = (state_q == ST_DONE);
  assign o_state        = state_q;

endmodule

// File: tb/tb_comm_sequencer.sv
// Directed bench for comm_sequencer (OS=4, FLUSH_BAUDS=8, WINDOW_BAUDS=16).
// A behavioural model (run-length phase, event counts) is compared against
// every output on every falling edge; literal checks pin the model.
module tb_comm_sequencer;
  localparam int OS = 4, NBAUDS = 6, FLUSH = 8, WIN = 16;

  logic       clock = 1'b0, reset = 1'b1;
  logic       tx_en = 1'b0, rx_en = 1'b0, start = 1'b0;
  logic [1:0] phase = 2'd0;
  logic       tx_baud, rx_samp, ber_clear, ber_window, busy, done;
  logic [1:0] state;
  int         n_checks = 0, n_fail = 0, cyc = 0;

  always #5 clock = ~clock;

  comm_sequencer #(.OS(OS), .NBAUDS(NBAUDS), .FLUSH_BAUDS(FLUSH), .WINDOW_BAUDS(WIN)) dut (
    .clock(clock), .reset(reset), .i_tx_en(tx_en), .i_rx_en(rx_en), .i_phase(phase),
    .i_start(start), .o_tx_baud_en(tx_baud), .o_rx_sample_en(rx_samp),
    .o_ber_clear(ber_clear), .o_ber_window(ber_window), .o_busy(busy), .o_done(done),
    .o_state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---- behavioural model ----
  // Phase is the number of consecutive tx-enabled clocks modulo OS; the FSM
  // is expressed as counts of baud/sample events.
  int m_run = 0, m_sel = 0, m_state = 0, m_bauds = 0, m_samples = 0;
  bit e_tx = 0, e_rx = 0, e_clr = 0, m_prev_start = 0;

  task automatic model_step();
    int ph;
    bit ntx, nrx;
    if (reset) begin
      m_run = 0; m_sel = 0; m_state = 0; m_bauds = 0; m_samples = 0;
      e_tx = 0; e_rx = 0; e_clr = 0; m_prev_start = 0;
      return;
    end
    ph  = m_run % OS;
    ntx = tx_en && (ph == OS - 1);
    nrx = tx_en && rx_en && (ph == m_sel);
    if (ph == OS - 1) m_sel = int'(phase);
    m_run = tx_en ? m_run + 1 : 0;
    e_clr = 0;
    if (!(tx_en && rx_en)) begin
      m_state = 0; m_bauds = 0; m_samples = 0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_bauds = 0; end
        1: if (e_tx) begin
             m_bauds++;
             if (m_bauds == FLUSH) begin m_state = 2; e_clr = 1; m_samples = 0; end
           end
        2: if (e_rx) begin
             m_samples++;
             if (m_samples == WIN) m_state = 3;
           end
        default: begin
`ifdef COMM_SEQ_CONTINUOUS_EN
          m_state = 2; e_clr = 1; m_samples = 0;
`else
          if (start && !m_prev_start) begin m_state = 1; m_bauds = 0; end
`endif
        end
      endcase
    end
    m_prev_start = start;
    e_tx = ntx;
    e_rx = nrx;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    model_step();
  end

  initial forever begin
    @(negedge clock);
    check("m_tx_baud",    tx_baud,    e_tx);
    check("m_rx_sample",  rx_samp,    e_rx);
    check("m_ber_clear",  ber_clear,  e_clr);
    check("m_ber_window", ber_window, m_state == 2);
    check("m_busy",       busy,       m_state == 1 || m_state == 2);
    check("m_done",       done,       m_state == 3);
    check("m_state",      state,      m_state);
  end

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (state != 2'(s) && n < budget) begin tick(); n++; end
    check("wait_state", state, s);
  endtask

  // ---- directed stimulus ----
  initial begin
    int n;
    tx_en = 1'b1;                 // phase would wrap if reset were ignored
    repeat (6) tick();
    check("rst_tx", tx_baud, 0);
    check("rst_state", state, 0);
    check("rst_outs", {rx_samp, ber_clear, ber_window, busy, done}, 0);
    reset = 1'b0;

    for (int i = 1; i <= 136; i++) begin
      tick();
      if (i <= 34) begin
        check("t1_tx_strobe", tx_baud, (i % 4 == 0));
        check("t2_rx_strobe", rx_samp, (i inside {13, 19, 23, 27, 30, 34}));
      end
      case (i)
        35:  begin check("t3_flush", state, 1); check("t3_busy", busy, 1); end
        64:  check("t3_still_flush", state, 1);
        65:  begin check("t3_measure", state, 2); check("t3_clear", ber_clear, 1); end
        66:  begin check("t3_clear_1cyc", ber_clear, 0); check("t3_window", ber_window, 1); end
        126: check("t3_last_sample_in_window", ber_window, 1);
        127: begin
          check("t3_done_state", state, 3); check("t3_done", done, 1);
          check("t3_window_off", ber_window, 0); check("t3_not_busy", busy, 0);
        end
`ifdef COMM_SEQ_CONTINUOUS_EN
        128: begin
          check("t6_remeasure", state, 2); check("t6_clear", ber_clear, 1);
          check("t6_done_pulse", done, 0);
        end
`else
        128, 131, 136: begin check("t3_done_held", done, 1); check("t3_state3", state, 3); end
`endif
        default: ;
      endcase
      if (i == 12) begin rx_en = 1'b1; phase = 2'd2; end
      if (i == 26) phase = 2'd1;
      if (i == 34) start = 1'b1;
      if (i == 36) start = 1'b0;
    end

    // Abort mid-MEASURE, then rerun with start still high.
    start = 1'b1;
    wait_state(2, 100);
    repeat (5) tick();
    rx_en = 1'b0;
    tick();
    check("t4_idle", state, 0);
    check("t4_window_off", ber_window, 0);
    check("t4_done_off", done, 0);
    check("t4_no_clear", ber_clear, 0);
    rx_en = 1'b1;
    tick();
    check("t4_restart", state, 1);
    n = 0;
    while (state == 2'd1 && n < 100) begin tick(); n++; end
    check("t4_full_flush_29_32", (n >= 29 && n <= 32), 1);
    check("t4_clear", ber_clear, 1);

    // Start held high through DONE.
    wait_state(3, 200);
`ifdef COMM_SEQ_CONTINUOUS_EN
    tick();
    check("t6_auto_measure", state, 2);
    check("t6_auto_clear", ber_clear, 1);
    check("t6_done_1cyc", done, 0);
    wait_state(3, 200);
    check("t6_second_done", done, 1);
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t5_held_no_restart", state, 3);
    end
    start = 1'b0;
    tick();
    check("t5_still_done", done, 1);
    start = 1'b1;
    tick();
    check("t5_edge_restart", state, 1);
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
